mq_pass_state_tracker: RTL and testbench
========================================

Name: mq_pass_state_tracker

Overview:
Parametrised successor of the MQ output-state generator. It tracks per-pass "last word" flags for any number of coding passes and registers the bit-plane flush-complete pulse. It also adds a per-code-block bit-plane sequencer, a pass counter and a block-complete pulse. It sits between the MQ coder flush logic and the bit-stream packer / rate-control bookkeeping.

Parameters:
NUM_PASS, 3, number of coding passes; pass code k (1..NUM_PASS) maps to word_last[k-1]; code 0 means idle.
PASS_W, 2, width of pass-code inputs; must satisfy 2^PASS_W > NUM_PASS.
BP_W, 5, width of the bit-plane count/index.
CNT_W, 7, width of pass_cnt; saturating.

Ports:
clk  in  1  system clock
rst_syn  in  1  synchronous reset, active-high
blk_start  in  1  single-cycle pulse; starts a code-block; honoured only in IDLE
num_bp_in  in  BP_W  number of bit-planes to code, sampled with blk_start
data_valid_pass_reg  in  PASS_W  pass code of the word currently accepted by the MQ coder
word_last_valid  in  PASS_W  pass code qualifying word_last_flag
word_last_flag  in  1  last-word indication for the qualified pass
flush_over  in  1  MQ flush finished for the current bit-plane (pulse)
word_last  out  NUM_PASS  per-pass last-word state; bit k-1 for pass code k
bp_code_over  out  1  registered bit-plane-complete pulse
bp_index  out  BP_W  remaining bit-planes minus one; counts down
pass_cnt  out  CNT_W  passes whose last word has been flagged in this block
busy  out  1  high in CODING
blk_code_over  out  1  single-cycle block-complete pulse

Behaviour:
- All outputs are registered. On rst_syn, every output goes to 0 and the FSM goes to IDLE. rst_syn has priority over everything, including mid-block.
- FSM states: IDLE, CODING, DONE.
  - IDLE + blk_start:
    - num_bp_in==0: go to DONE; bp_index=0.
    - Otherwise: go to CODING; bp_index=num_bp_in-1; pass_cnt=0; word_last=0.
  - CODING + bp_code_over:
    - bp_index==0: go to DONE.
    - Otherwise: bp_index decrements and the FSM stays in CODING.
  - DONE: blk_code_over=1 for exactly one cycle; unconditionally return to IDLE.
  - blk_start outside IDLE: ignored.
- busy=1 exactly while in CODING.
- bp_code_over:
  - Next-cycle copy of flush_over when the FSM is in CODING; otherwise 0.
  - Latency from flush_over to bp_code_over is 1 cycle.
  - Latency from flush_over to the bp_index change is 2 cycles.
- word_last[k-1], for k = 1..NUM_PASS, evaluated in CODING only:
  - If word_last_valid==k and data_valid_pass_reg==k: load word_last_flag.
  - Else if bp_code_over: clear to 0.
  - Else: hold.
  - The load takes priority over the clear when both occur in the same cycle.
  - Pass code 0, or codes above NUM_PASS, never load any bit.
- pass_cnt:
  - Increments by 1 on any cycle where a load writes 1 into a word_last bit that is currently 0 (rising edge only).
  - Saturates at 2^CNT_W-1.
  - Cleared only by blk_start accepted in IDLE, or by rst_syn.
- word_last_valid and data_valid_pass_reg carry one pass code per cycle, so at most one word_last bit changes by load per cycle.
- flush_over in IDLE or DONE is dropped: no bp_code_over, no state change.

Decomposition:
- Shared package mq_pkg:
  - localparams PASS_IDLE=0, PASS_SP=1, PASS_MRP=2, PASS_CP=3;
  - FSM state encoding (IDLE/CODING/DONE, 2 bits).
- Sub-module mq_pass_last_latch: one per pass via generate. Inputs: clk, rst_syn, en, load, clr, d. Outputs: q and a rise pulse used by the pass counter. The top level holds the FSM, bp_index and pass_cnt.

Test Plan:
- Reset mid-block: rst_syn=1 while in CODING with word_last=3'b101 and bp_index=4 -> next cycle every output is 0 and the FSM is IDLE; blk_start without num_bp_in reload is never required.
- Single pass flag: blk_start with num_bp_in=3, then word_last_valid=data_valid_pass_reg=2 and word_last_flag=1 -> word_last=3'b010 and pass_cnt=1 one cycle later; a mismatch (word_last_valid=2, data_valid_pass_reg=1) leaves word_last unchanged.
- Bit-plane sequencing: num_bp_in=3 with three flush_over pulses -> three bp_code_over pulses, each 1 cycle after its flush_over; bp_index goes 2->1->0; blk_code_over pulses one cycle after DONE is entered; busy=0 afterwards.
- Simultaneous events: bp_code_over=1 in the same cycle as a load for pass 3 with flag=1 -> word_last[2]=1 while the other bits clear; pass_cnt increments once.
- Edge cases:
  - num_bp_in=0 -> blk_code_over one cycle after DONE, busy never asserts.
  - flush_over in IDLE -> no bp_code_over.
  - blk_start during CODING -> ignored; bp_index unchanged.
- Saturation: with CNT_W=2, five pass rises within one block -> pass_cnt stops at 3.

Source files
------------

// File: rtl/mq_pass_state_tracker_pkg.sv
// Shared definitions for the MQ pass-state tracker: pass codes and FSM state encoding.
package mq_pkg;

  localparam int PASS_IDLE = 0;
  localparam int PASS_SP   = 1;
  localparam int PASS_MRP  = 2;
  localparam int PASS_CP   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CODING = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/mq_pass_state_tracker_if.sv
// Flush-logic / packer side signals of the pass-state tracker, grouped with driver and tracker views.
interface mq_pass_state_tracker_if #(
  parameter int NUM_PASS = 3,
  parameter int PASS_W   = 2,
  parameter int BP_W     = 5,
  parameter int CNT_W    = 7
);
  logic                blk_start;
  logic [BP_W-1:0]     num_bp_in;
  logic [PASS_W-1:0]   data_valid_pass_reg;
  logic [PASS_W-1:0]   word_last_valid;
  logic                word_last_flag;
  logic                flush_over;
  logic [NUM_PASS-1:0] word_last;
  logic                bp_code_over;
  logic [BP_W-1:0]     bp_index;
  logic [CNT_W-1:0]    pass_cnt;
  logic                busy;
  logic                blk_code_over;

  modport master (
    output blk_start, num_bp_in, data_valid_pass_reg, word_last_valid, word_last_flag, flush_over,
    input  word_last, bp_code_over, bp_index, pass_cnt, busy, blk_code_over
  );

  modport slave (
    input  blk_start, num_bp_in, data_valid_pass_reg, word_last_valid, word_last_flag, flush_over,
    output word_last, bp_code_over, bp_index, pass_cnt, busy, blk_code_over
  );
endinterface

// File: rtl/mq_pass_last_latch.sv
// One pass's last-word flag; a load beats a clear, and rise flags a 0->1 load for the pass counter.
module mq_pass_last_latch (
  input  logic clk,
  input  logic rst_syn,
  input  logic en,
  input  logic load,
  input  logic clr,
  input  logic d,
  output logic q,
  output logic rise
);
  logic r_q;

  always_ff @(posedge clk) begin
    if (rst_syn) begin
      r_q <= 1'b0;
    end else if (en) begin
      if (load)     r_q <= d;
      else if (clr) r_q <= 1'b0;
    end
  end

  assign q    = r_q;
  assign rise = en & load & d & ~r_q;
endmodule

// File: rtl/mq_pass_state_tracker.sv
// Per-block bit-plane sequencer with per-pass last-word flags, pass counter and completion pulses.
module mq_pass_state_tracker #(
  parameter int NUM_PASS = 3,
  parameter int PASS_W   = 2,
  parameter int BP_W     = 5,
  parameter int CNT_W    = 7
) (
  input  logic                    clk,
  input  logic                    rst_syn,
  mq_pass_state_tracker_if.slave  bus
);
  import mq_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              r_state, w_state_nxt;
  logic [BP_W-1:0]     r_bp_index, w_bp_index_nxt;
  logic                r_bp_code_over, r_busy, r_blk_code_over;
  logic [CNT_W-1:0]    r_pass_cnt;
  logic                w_coding, w_start, w_start_clr;
  logic [NUM_PASS-1:0] w_load, w_rise, w_q;

  assign w_coding    = (r_state == ST_CODING);
  assign w_start     = (r_state == ST_IDLE) && bus.blk_start;
  assign w_start_clr = w_start && (bus.num_bp_in != '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_bp_index_nxt = r_bp_index;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.blk_start) begin
          if (bus.num_bp_in == '0) begin
            w_state_nxt    = ST_DONE;
            w_bp_index_nxt = '0;
          end else begin
            w_state_nxt    = ST_CODING;
            w_bp_index_nxt = bus.num_bp_in - BP_W'(1);
          end
        end
      end
      ST_CODING: begin
        if (r_bp_code_over) begin
          if (r_bp_index == '0) w_state_nxt    = ST_DONE;
          else                  w_bp_index_nxt = r_bp_index - BP_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_syn) begin
      r_state         <= ST_IDLE;
      r_bp_index      <= '0;
      r_bp_code_over  <= 1'b0;
      r_busy          <= 1'b0;
      r_blk_code_over <= 1'b0;
      r_pass_cnt      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_bp_index      <= w_bp_index_nxt;
      r_bp_code_over  <= w_coding & bus.flush_over;
      // busy follows the next state so it is high exactly while the FSM sits in CODING
      r_busy          <= (w_state_nxt == ST_CODING);
      r_blk_code_over <= (r_state == ST_DONE);
      if (w_start)
        r_pass_cnt <= '0;
      else if ((|w_rise) && (r_pass_cnt != CNT_MAX))
        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 1; k <= NUM_PASS; k++) begin : g_pass
    assign w_load[k-1] = w_coding &&
                         (bus.word_last_valid == PASS_W'(k)) &&
                         (bus.data_valid_pass_reg == PASS_W'(k));

    mq_pass_last_latch u_latch (
      .clk     (clk),
      .rst_syn (rst_syn),
      .en      (w_coding | w_start_clr),
      .load    (w_load[k-1]),
      .clr     (r_bp_code_over | w_start_clr),
      .d       (bus.word_last_flag),
      .q       (w_q[k-1]),
      .rise    (w_rise[k-1])
    );
  end

  assign bus.word_last     = w_q;
  assign bus.bp_code_over  = r_bp_code_over;
  assign bus.bp_index      = r_bp_index;
  assign bus.pass_cnt      = r_pass_cnt;
  assign bus.busy          = r_busy;
  assign bus.blk_code_over = r_blk_code_over;
endmodule

// File: tb/tb_mq_pass_state_tracker.sv
// Scoreboard bench: two trackers (wide and 2-bit pass counter) share stimulus; a block-level model predicts outputs.
module tb_mq_pass_state_tracker;
  localparam int NUM_PASS = 3;
  localparam int PASS_W   = 2;
  localparam int BP_W     = 5;
  localparam int CNT_WA   = 7;
  localparam int CNT_WB   = 2;

  logic clk = 1'b0;
  logic rst_syn = 1'b1;
  always #5 clk = ~clk;

  mq_pass_state_tracker_if #(.NUM_PASS(NUM_PASS), .PASS_W(PASS_W), .BP_W(BP_W), .CNT_W(CNT_WA)) ifa ();
  mq_pass_state_tracker_if #(.NUM_PASS(NUM_PASS), .PASS_W(PASS_W), .BP_W(BP_W), .CNT_W(CNT_WB)) ifb ();

  mq_pass_state_tracker #(.NUM_PASS(NUM_PASS), .PASS_W(PASS_W), .BP_W(BP_W), .CNT_W(CNT_WA)) u_dut_a (
    .clk(clk), .rst_syn(rst_syn), .bus(ifa.slave));
  mq_pass_state_tracker #(.NUM_PASS(NUM_PASS), .PASS_W(PASS_W), .BP_W(BP_W), .CNT_W(CNT_WB)) u_dut_b (
    .clk(clk), .rst_syn(rst_syn), .bus(ifb.slave));

  typedef struct {
    logic [NUM_PASS-1:0] wl;
    logic                bpo;
    logic [BP_W-1:0]     idx;
    int                  cnt;
    logic                busy;
    logic                bco;
  } exp_t;

  exp_t sbq[$];
  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: block phase (0 idle, 1 coding, 2 done), planes left, flags, unbounded pass count.
  int              m_phase = 0;
  int              m_left  = 0;
  bit [NUM_PASS-1:0] m_wl  = '0;
  int              m_cnt   = 0;
  bit              m_bpo = 0, m_busy = 0, m_bco = 0;

  task automatic model_step(bit r, bit st, int nbp, int dv, int wv, bit fl, bit fo);
    bit   prev_bpo;
    int   prev_phase;
    exp_t e;
    prev_bpo   = m_bpo;
    prev_phase = m_phase;
    if (r) begin
      m_phase = 0; m_left = 0; m_wl = '0; m_cnt = 0;
      m_bpo = 0; m_busy = 0; m_bco = 0;
    end else begin
      m_bpo = (prev_phase == 1) && fo;
      m_bco = (prev_phase == 2);
      if (prev_phase == 0 && st) begin
        m_cnt  = 0;
        m_left = (nbp == 0) ? 0 : nbp - 1;
        if (nbp != 0) m_wl = '0;
        m_phase = (nbp == 0) ? 2 : 1;
      end else if (prev_phase == 1) begin
        for (int k = 1; k <= NUM_PASS; k++) begin
          if (wv == k && dv == k) begin
            if (fl && !m_wl[k-1]) m_cnt++;
            m_wl[k-1] = fl;
          end else if (prev_bpo) begin
            m_wl[k-1] = 1'b0;
          end
        end
        if (prev_bpo) begin
          if (m_left == 0) m_phase = 2;
          else             m_left--;
        end
      end else if (prev_phase == 2) begin
        m_phase = 0;
      end
      m_busy = (m_phase == 1);
    end
    e.wl = m_wl; e.bpo = m_bpo; e.idx = BP_W'(m_left);
    e.cnt = m_cnt; e.busy = m_busy; e.bco = m_bco;
    sbq.push_back(e);
  endtask

  task automatic cyc(bit r, bit st, int nbp, int dv, int wv, bit fl, bit fo);
    @(negedge clk);
    rst_syn = r;
    ifa.blk_start = st;                      ifb.blk_start = st;
    ifa.num_bp_in = BP_W'(nbp);              ifb.num_bp_in = BP_W'(nbp);
    ifa.data_valid_pass_reg = PASS_W'(dv);   ifb.data_valid_pass_reg = PASS_W'(dv);
    ifa.word_last_valid = PASS_W'(wv);       ifb.word_last_valid = PASS_W'(wv);
    ifa.word_last_flag = fl;                 ifb.word_last_flag = fl;
    ifa.flush_over = fo;                     ifb.flush_over = fo;
    model_step(r, st, nbp, dv, wv, fl, fo);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Monitor: one expected output set per clock, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("A.word_last",     32'(ifa.word_last),     32'(e.wl));
      chk("A.bp_code_over",  32'(ifa.bp_code_over),  32'(e.bpo));
      chk("A.bp_index",      32'(ifa.bp_index),      32'(e.idx));
      chk("A.pass_cnt",      32'(ifa.pass_cnt),      32'((e.cnt > 127) ? 127 : e.cnt));
      chk("A.busy",          32'(ifa.busy),          32'(e.busy));
      chk("A.blk_code_over", 32'(ifa.blk_code_over), 32'(e.bco));
      chk("B.word_last",     32'(ifb.word_last),     32'(e.wl));
      chk("B.bp_index",      32'(ifb.bp_index),      32'(e.idx));
      chk("B.pass_cnt",      32'(ifb.pass_cnt),      32'((e.cnt > 3) ? 3 : e.cnt));
      chk("B.blk_code_over", 32'(ifb.blk_code_over), 32'(e.bco));
    end
  end

  initial begin
    int dv, wv, nbp;
    bit r, st, fl, fo;
    ifa.blk_start = 0; ifa.num_bp_in = '0; ifa.data_valid_pass_reg = '0;
    ifa.word_last_valid = '0; ifa.word_last_flag = 0; ifa.flush_over = 0;
    ifb.blk_start = 0; ifb.num_bp_in = '0; ifb.data_valid_pass_reg = '0;
    ifb.word_last_valid = '0; ifb.word_last_flag = 0; ifb.flush_over = 0;

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // reset in the middle of a block: word_last=101, bp_index=4
    cyc(0, 1, 5, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 3, 3, 1, 0);
    idle(1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // single pass flag, mismatched qualifier, ignored blk_start, three bit-planes
    cyc(0, 1, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 2, 2, 1, 0);
    cyc(0, 0, 0, 1, 2, 0, 0);
    cyc(0, 1, 7, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // five rises saturate the 2-bit counter; then load for pass 3 together with bp_code_over
    cyc(0, 1, 4, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 2, 2, 1, 0);
    cyc(0, 0, 0, 3, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 2, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 3, 3, 1, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // zero bit-planes, then flush_over while idle
    cyc(0, 1, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);

    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 7) == 0);
      nbp = $urandom_range(0, 4);
      dv  = $urandom_range(0, 3);
      wv  = ($urandom_range(0, 1) == 0) ? dv : $urandom_range(0, 3);
      fl  = 1'($urandom_range(0, 1));
      fo  = ($urandom_range(0, 5) == 0);
      cyc(r, st, nbp, dv, wv, fl, fo);
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
